tx_dac_interp: RTL

Transmit-side counterpart of the RX DSP chain. Accepts the FIR-chain IQ stream (AXI-stream, DSP_WIDTH per channel) and feeds a DAC that pulls one sample per `dac_req` strobe. Integer interpolation is done by zero-order hold or zero-stuffing, with optional DC offset pre-compensation. The output is rounded and saturated to DAC_WIDTH. Underruns are detected and recovered through a prime/run state machine.

---
 rtl/tx_dac_interp_if.sv | 17 +
 rtl/tx_dac_interp.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tx_dac_interp_if.sv
// Sample streams of tx_dac_interp: FIR-chain IQ input side and DAC pull side.
interface tx_dac_interp_if #(
  parameter int DSP_WIDTH = 16,
  parameter int DAC_WIDTH = 12
);
  logic [2*DSP_WIDTH-1:0] dsp_data;
  logic                   dsp_valid;
  logic                   dsp_ready;
  logic                   dac_req;
  logic [2*DAC_WIDTH-1:0] dac_data;
  logic                   dac_valid;

  modport master (output dsp_data, dsp_valid, dac_req,
                  input  dsp_ready, dac_data, dac_valid);
  modport slave  (input  dsp_data, dsp_valid, dac_req,
                  output dsp_ready, dac_data, dac_valid);
endinterface

// File: rtl/tx_dac_interp.sv
// TX interpolator feeding a pull-mode DAC: hold/zero-stuff, round+saturate, underrun recovery.
// Optional DC offset pre-compensation is built when macro TX_DC_CORR_EN is defined.
//
// state | meaning
// IDLE  | disabled, FIFO flushed, zeros out
// PRIME | refilling FIFO up to PRIME_LEVEL, zeros out
// RUN   | popping one sample per interp requests
module tx_dac_interp #(
  parameter int DAC_WIDTH      = 12,
  parameter int DSP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 32,
  parameter int FIFO_DEEP_BITS = 2,
  parameter int PRIME_LEVEL    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tx_dac_interp_if.slave              bus,
  input  logic                        cfg_valid_i,
  input  logic [CFG_WIDTH-1:0]        cfg_data_i,
  input  logic signed [DSP_WIDTH-1:0] cfg_dc_i_i,
  input  logic signed [DSP_WIDTH-1:0] cfg_dc_q_i,
  output logic                        underrun_o,
  output logic [15:0]                 underrun_cnt_o
);
  localparam int DEPTH = 1 << FIFO_DEEP_BITS;
  localparam int CW    = FIFO_DEEP_BITS + 1;
  localparam int S     = DSP_WIDTH - DAC_WIDTH;
  localparam int SH    = (S > 0) ? S - 1 : 0;
  localparam logic signed [DSP_WIDTH+1:0] HALF = (S > 0) ? (DSP_WIDTH+2)'(2 ** SH) : '0;
  localparam logic signed [DSP_WIDTH+1:0] MAXV = (DSP_WIDTH+2)'(2 ** (DAC_WIDTH-1) - 1);
  localparam logic signed [DSP_WIDTH+1:0] MINV = (DSP_WIDTH+2)'(-(2 ** (DAC_WIDTH-1)));

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                        state_q;
  logic [7:0]                    interp_m1_q, ph_q;
  logic                          zs_q, en_q, pend_q;
  logic [9:0]                    shadow_q;
  logic [2*DSP_WIDTH-1:0]        mem_q [DEPTH];
  logic [FIFO_DEEP_BITS-1:0]     wr_q, rd_q;
  logic [CW-1:0]                 cnt_q;
  logic [2*DSP_WIDTH-1:0]        cur_q;
  logic                          s1_vld_q, dac_valid_q, underrun_q;
  logic signed [DSP_WIDTH:0]     s1_i_q, s1_q_q;
  logic [2*DAC_WIDTH-1:0]        dac_data_q;
  logic [15:0]                   ucnt_q;

  logic                          full, empty, push, pop, run_req, urun, add_dc, cfg_apply;
  logic [2*DSP_WIDTH-1:0]        head, sel;
  logic [9:0]                    cfg_nxt;
  logic signed [DSP_WIDTH:0]     sum_i, sum_q;
  logic                          cfg_unused;

  assign cfg_unused = ^cfg_data_i[CFG_WIDTH-1:10];

  function automatic logic [DAC_WIDTH-1:0] rnd_sat(input logic signed [DSP_WIDTH:0] x);
    logic signed [DSP_WIDTH+1:0] r;
    r = $signed({x[DSP_WIDTH], x}) + HALF;
    r = r >>> S;
    if (r > MAXV)      return MAXV[DAC_WIDTH-1:0];
    else if (r < MINV) return MINV[DAC_WIDTH-1:0];
    else               return r[DAC_WIDTH-1:0];
  endfunction

  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    empty     = (cnt_q == '0);
    head      = mem_q[rd_q];
    push      = bus.dsp_valid && bus.dsp_ready;
    run_req   = (state_q == RUN) && bus.dac_req;
    pop       = run_req && (ph_q == 8'd0) && !empty;
    urun      = run_req && (ph_q == 8'd0) && empty;
    add_dc    = run_req && !urun;
    sel       = '0;
    if (pop)
      sel = head;
    else if (run_req && (ph_q != 8'd0) && !zs_q)
      sel = cur_q;
    cfg_nxt   = cfg_valid_i ? cfg_data_i[9:0] : shadow_q;
    cfg_apply = (cfg_valid_i || pend_q) && ((state_q == IDLE) || (ph_q == 8'd0));
`ifdef TX_DC_CORR_EN
    sum_i = {sel[DSP_WIDTH-1], sel[DSP_WIDTH-1:0]}
          + (add_dc ? {cfg_dc_i_i[DSP_WIDTH-1], cfg_dc_i_i} : '0);
    sum_q = {sel[2*DSP_WIDTH-1], sel[2*DSP_WIDTH-1:DSP_WIDTH]}
          + (add_dc ? {cfg_dc_q_i[DSP_WIDTH-1], cfg_dc_q_i} : '0);
`else
    sum_i = {sel[DSP_WIDTH-1], sel[DSP_WIDTH-1:0]};
    sum_q = {sel[2*DSP_WIDTH-1], sel[2*DSP_WIDTH-1:DSP_WIDTH]};
`endif
  end

`ifndef TX_DC_CORR_EN
  logic dc_unused;
  assign dc_unused = ^{cfg_dc_i_i, cfg_dc_q_i, add_dc};
`endif

  assign bus.dsp_ready  = (state_q != IDLE) && en_q && !full;
  assign bus.dac_data   = dac_data_q;
  assign bus.dac_valid  = dac_valid_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      interp_m1_q <= '0;
      ph_q        <= '0;
      zs_q        <= 1'b0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      shadow_q    <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_i_q      <= '0;
      s1_q_q      <= '0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      if (cfg_valid_i) shadow_q <= cfg_data_i[9:0];
      if (cfg_apply) begin
        {en_q, zs_q, interp_m1_q} <= cfg_nxt;
        pend_q <= 1'b0;
      end else if (cfg_valid_i) begin
        pend_q <= 1'b1;
      end

      if (state_q == IDLE) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_q] <= bus.dsp_data;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
      if (pop) cur_q <= head;

      if (!en_q) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE:    state_q <= PRIME;
          PRIME:   if (cnt_q >= CW'(PRIME_LEVEL)) state_q <= RUN;
          RUN:     if (urun) state_q <= PRIME;
          default: state_q <= IDLE;
        endcase
      end

      // wrap on >= so a shorter interp taking effect mid-count cannot overrun
      if ((state_q != RUN) || urun) ph_q <= '0;
      else if (bus.dac_req)         ph_q <= (ph_q >= interp_m1_q) ? 8'd0 : ph_q + 8'd1;

      if (urun) begin
        underrun_q <= 1'b1;
        ucnt_q     <= cfg_valid_i ? 16'd1 : ((ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1);
      end else if (cfg_valid_i) begin
        underrun_q <= 1'b0;
        ucnt_q     <= '0;
      end

      s1_vld_q    <= bus.dac_req;
      s1_i_q      <= sum_i;
      s1_q_q      <= sum_q;
      dac_valid_q <= s1_vld_q;
      if (s1_vld_q) dac_data_q <= {rnd_sat(s1_q_q), rnd_sat(s1_i_q)};
    end
  end
endmodule
